rom: RTL and testbench

- 16 x 8 program/data memory for the SAP-1 computer.
- Drives the shared 8-bit W-bus when its active-low enable CE_bar is asserted; otherwise it releases the bus (high-Z).
- Contents load from a built-in default SAP-1 program on reset.
- A synchronous programming port (the "switch register") overwrites individual words.

---
 rtl/sap1_pkg.sv | 35 +++
 rtl/rom.sv | 40 ++++
 tb/tb_rom.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: opcodes, widths and the
// power-on program image used by the ROM and its checkers.
package sap1_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [7:0] instr(
    input logic [3:0] op,
    input logic [3:0] arg
  );
    return {op, arg};
  endfunction

  // LDA 9; ADD A; ADD B; SUB C; OUT; HLT -> 0x10+0x14+0x18-0x20 = 0x1C
  localparam logic [7:0] DEFAULT_IMAGE [16] = '{
    8'h09, 8'h1A, 8'h1B, 8'h2C,
    8'hE0, 8'hF0, 8'h00, 8'h00,
    8'h00, 8'h10, 8'h14, 8'h18,
    8'h20, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] default_word(input int idx);
    if (idx < 16) return DEFAULT_IMAGE[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/rom.sv
// SAP-1 16x8 program memory with W-bus tri-state driver
// and a synchronous switch-register programming port.
module rom
  import sap1_pkg::*;
#(
  parameter int ADDR_W = sap1_pkg::ADDR_W,
  parameter int DATA_W = sap1_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ROM_address,
  input  logic              CE_bar,
  output tri   [DATA_W-1:0] ROM_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  localparam int DEPTH_W = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH_W];
  logic              drive;

  // Flops rather than RAM so reset can restore the image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_W; i++) begin
        mem[i] <= DATA_W'(default_word(i));
      end
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Unknown enable or reset is treated as not driving.
  assign drive = (CE_bar === 1'b0) && (rst === 1'b0);

  assign ROM_data = drive ? mem[ROM_address] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rom.sv
// Self-checking bench for the SAP-1 ROM against a
// spec-level array model with random programming traffic.
module tb_rom;

  logic       clk;
  logic       rst;
  logic [3:0] rom_address;
  logic       ce_bar;
  tri   [7:0] rom_data;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;

  logic       hiz;
  logic [7:0] model [16];
  logic [7:0] golden [16];
  int         checks;
  int         errors;

  rom dut (
    .clk        (clk),
    .rst        (rst),
    .ROM_address(rom_address),
    .CE_bar     (ce_bar),
    .ROM_data   (rom_data),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data)
  );

  assign hiz = (rom_data === 8'hzz);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_read(input string tag);
    if (ce_bar) check({tag, "_z"}, {7'd0, hiz}, 8'd1);
    else begin
      check({tag, "_drv"}, {7'd0, hiz}, 8'd0);
      check(tag, rom_data, model[rom_address]);
    end
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) model[i] = golden[i];
  endtask

  initial begin
    int pcnt;
    checks = 0;
    errors = 0;
    golden = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
               8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00};
    load_default();
    rst = 1'b1;
    ce_bar = 1'b0;
    rom_address = 4'h0;
    prog_we = 1'b0;
    prog_addr = 4'h0;
    prog_data = 8'h00;
    #1;
    check("reset_z", {7'd0, hiz}, 8'd1);
    #22 rst = 1'b0;

    // Default image sweep
    for (int a = 0; a < 16; a++) begin
      rom_address = 4'(a);
      #1 check_read("sweep");
    end

    // Disabled sweep, then re-enable at address 3
    ce_bar = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rom_address = 4'(a);
      #1 check_read("ce_off");
    end
    rom_address = 4'h3;
    #1 ce_bar = 1'b0;
    #0 check("ce_on_3", rom_data, 8'h2C);

    // Write A5 to addr 7 while reading addr 7
    @(negedge clk);
    rom_address = 4'h7;
    prog_we = 1'b1; prog_addr = 4'h7; prog_data = 8'hA5;
    #1 check("wr7_pre", rom_data, 8'h00);
    @(posedge clk); #1;
    prog_we = 1'b0;
    check("wr7_post", rom_data, 8'hA5);
    model[7] = 8'hA5;
    for (int a = 0; a < 16; a++) begin
      rom_address = 4'(a);
      #1 check_read("after_wr7");
    end

    // Read-during-write on addr 2, no bypass
    @(negedge clk);
    rom_address = 4'h2;
    prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'h3C;
    #1 check("rdw_pre", rom_data, 8'h1B);
    @(posedge clk); #1;
    prog_we = 1'b0;
    check("rdw_post", rom_data, 8'h3C);
    model[2] = 8'h3C;

    // Program addr 0, then async reset between edges
    @(negedge clk);
    rom_address = 4'h0;
    prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'hFF;
    @(posedge clk); #1;
    prog_we = 1'b0;
    check("prog0", rom_data, 8'hFF);
    #1 rst = 1'b1;
    #1 check("rst_z", {7'd0, hiz}, 8'd1);
    prog_we = 1'b1; prog_addr = 4'h5; prog_data = 8'h77;
    @(posedge clk); #1;
    prog_we = 1'b0;
    rst = 1'b0;
    load_default();
    #1 check("rst_rel0", rom_data, 8'h09);
    rom_address = 4'h5;
    #1 check("rst_nowr", rom_data, 8'hF0);
    rom_address = 4'h2;
    #1 check("rst_lost", rom_data, 8'h1B);

    // Counter address, 32 cycles low / 10 high enable, random writes
    rom_address = 4'h0;
    pcnt = 0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      ce_bar = (pcnt >= 32);
      pcnt = (pcnt == 41) ? 0 : pcnt + 1;
      prog_we = ($urandom_range(0, 3) == 0);
      prog_addr = 4'($urandom);
      prog_data = 8'($urandom);
      #1 check_read("cnt_pre");
      @(posedge clk);
      if (prog_we) model[prog_addr] = prog_data;
      #1 check_read("cnt_post");
      rom_address = rom_address + 4'h1;
    end

    // Wrap from F back to 0 after a fresh reset
    prog_we = 1'b0;
    ce_bar = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    load_default();
    rom_address = 4'hF;
    #1 check("wrap_f", rom_data, 8'h00);
    rom_address = rom_address + 4'h1;
    #1 check("wrap_0", rom_data, 8'h09);

    // Fully random reads with random enable
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rom_address = 4'($urandom);
      ce_bar = $urandom_range(0, 1) == 1;
      prog_we = $urandom_range(0, 1) == 1;
      prog_addr = 4'($urandom);
      prog_data = 8'($urandom);
      #1 check_read("rnd_pre");
      @(posedge clk);
      if (prog_we) model[prog_addr] = prog_data;
      #1 check_read("rnd_post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
